// File: rtl/seg_frame_driver_pkg.sv
// Shared constants for the 6-digit 7-segment frame driver: digit geometry,
// scan-FSM digit indices and the {g,f,e,d,c,b,a} hex glyph table.
package seg_frame_driver_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int FRAME_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [3:0] DIG0 = 4'd0;
  localparam logic [3:0] DIG1 = 4'd1;
  localparam logic [3:0] DIG2 = 4'd2;
  localparam logic [3:0] DIG3 = 4'd3;
  localparam logic [3:0] DIG4 = 4'd4;
  localparam logic [3:0] DIG5 = 4'd5;

  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/seg_frame_driver_seg7_hex_decode.sv
// 4-bit value to 7-segment glyph {g,f,e,d,c,b,a}, active-high.
// Purely combinational, zero latency, no flow control.
module seg7_hex_decode
  import seg_frame_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (hex)
      4'h0: glyph = SEG_HEX_0;
      4'h1: glyph = SEG_HEX_1;
      4'h2: glyph = SEG_HEX_2;
      4'h3: glyph = SEG_HEX_3;
      4'h4: glyph = SEG_HEX_4;
      4'h5: glyph = SEG_HEX_5;
      4'h6: glyph = SEG_HEX_6;
      4'h7: glyph = SEG_HEX_7;
      4'h8: glyph = SEG_HEX_8;
      4'h9: glyph = SEG_HEX_9;
      4'hA: glyph = SEG_HEX_A;
      4'hB: glyph = SEG_HEX_B;
      4'hC: glyph = SEG_HEX_C;
      4'hD: glyph = SEG_HEX_D;
      4'hE: glyph = SEG_HEX_E;
      default: glyph = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_frame_driver.sv
// 6-digit 7-seg driver: double-buffered frame swapped at scan wrap, anti-ghost blanking, LZ suppression.
// Outputs registered 1 cycle after d; frame_ready = !pending, an offer is held off until the next wrap swap.
module seg_frame_driver
  import seg_frame_driver_pkg::*;
#(
  parameter int BLANK_CYCLES   = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_W-1:0]    frame_data,
  input  logic [NUM_DIGITS-1:0] frame_dp,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic                  blank_lz,
  input  logic [3:0]            d,
  input  logic [NUM_DIGITS-1:0] seg_sel,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYCLES);

  logic [FRAME_W-1:0]    act_dat, pend_dat, act_nxt_dat;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp, act_nxt_dp;
  logic                  pend_vld;
  logic                  accept, wrap, swap, change, dig_ok;
  logic [3:0]            d_q, blank_cnt, blank_nxt;
  logic [DIGIT_W-1:0]    dig_val;
  logic                  dig_dp, lead_zero, lz_kill;
  logic [6:0]            dig_glyph, seg_nxt, seg_q;
  logic                  dp_nxt, dp_q;
  logic [NUM_DIGITS-1:0] an_nxt, an_q;

  assign frame_ready = !pend_vld;
  assign accept      = frame_valid && !pend_vld;
  assign wrap        = (d_q == DIG5) && (d == DIG0);
  assign swap        = wrap && pend_vld;
  assign change      = (d != d_q);
  assign dig_ok      = (d <= DIG5);

  // Decode looks at the post-swap frame so the first digit after wrap is already the new one.
  assign act_nxt_dat = swap ? pend_dat : act_dat;
  assign act_nxt_dp  = swap ? pend_dp  : act_dp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld <= 1'b0;
      pend_dat <= '0;
      pend_dp  <= '0;
      act_dat  <= '0;
      act_dp   <= '0;
    end else begin
      if (accept) begin
        pend_vld <= 1'b1;
        pend_dat <= frame_data;
        pend_dp  <= frame_dp;
      end else if (swap) begin
        pend_vld <= 1'b0;
      end
      act_dat <= act_nxt_dat;
      act_dp  <= act_nxt_dp;
    end
  end

  always_comb begin
    blank_nxt = blank_cnt;
    if (change) begin
      blank_nxt = BLANK_INIT;
    end else if (blank_cnt != 4'd0) begin
      blank_nxt = blank_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q       <= DIG0;
      blank_cnt <= BLANK_INIT;
    end else begin
      d_q       <= d;
      blank_cnt <= blank_nxt;
    end
  end

  // lead_zero accumulates left to right, so at digit k it means digits 0..k are all zero.
  always_comb begin
    dig_val   = '0;
    dig_dp    = 1'b0;
    lz_kill   = 1'b0;
    lead_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lead_zero = lead_zero && (act_nxt_dat[DIGIT_W*(NUM_DIGITS-1-k) +: DIGIT_W] == '0);
      if (d == 4'(k)) begin
        dig_val = act_nxt_dat[DIGIT_W*(NUM_DIGITS-1-k) +: DIGIT_W];
        dig_dp  = act_nxt_dp[NUM_DIGITS-1-k];
        lz_kill = blank_lz && lead_zero && (k != NUM_DIGITS-1);
      end
    end
  end

  seg7_hex_decode u_decode (
    .hex   (dig_val),
    .glyph (dig_glyph)
  );

  always_comb begin
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    an_nxt  = '0;
    if (dig_ok) begin
      seg_nxt = lz_kill ? SEG_OFF : dig_glyph;
      dp_nxt  = dig_dp;
      an_nxt  = (blank_nxt == 4'd0) ? seg_sel : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
      an_q  <= '0;
    end else begin
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
      an_q  <= an_nxt;
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp  = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
  assign an  = AN_ACTIVE_LOW  ? ~an_q  : an_q;

endmodule

// File: tb/tb_seg_frame_driver.sv
// Directed bench for seg_frame_driver: stimulus pushes hand-computed per-cycle
// expectations into a queue, a negedge monitor pops and compares them.
module tb_seg_frame_driver;

  logic        clk;
  logic        reset;
  logic [23:0] frame_data;
  logic [5:0]  frame_dp;
  logic        frame_valid;
  logic        frame_ready;
  logic        blank_lz;
  logic [3:0]  d;
  logic [5:0]  seg_sel;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;

  seg_frame_driver #(
    .BLANK_CYCLES   (4),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_data  (frame_data),
    .frame_dp    (frame_dp),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .blank_lz    (blank_lz),
    .d           (d),
    .seg_sel     (seg_sel),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  typedef struct {
    int         due;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expectation for the outputs after the coming clock edge.
  task automatic push(input logic [6:0] es, input logic edp, input logic [5:0] ean, input logic erdy);
    exp_t e;
    e.due = cyc + 1;
    e.seg = es;
    e.dp  = edp;
    e.an  = ean;
    e.rdy = erdy;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      cmp($sformatf("due_cycle@%0d", e.due), e.due, cyc);
      cmp($sformatf("seg@%0d", e.due), seg, e.seg);
      cmp($sformatf("dp@%0d", e.due), dp, e.dp);
      cmp($sformatf("an@%0d", e.due), an, e.an);
      cmp($sformatf("frame_ready@%0d", e.due), frame_ready, e.rdy);
    end
  end

  // Hold one digit index for h cycles; an shows sel once nb blank edges have passed.
  task automatic hold(input logic [3:0] dd, input logic [5:0] sel, input logic [6:0] es,
                      input logic edp, input int nb, input logic r0, input logic rr, input int h);
    logic acc;
    for (int i = 0; i < h; i++) begin
      d       = dd;
      seg_sel = sel;
      push(es, edp, (dd <= 4'd5 && i >= nb) ? sel : 6'h00, (i == 0) ? r0 : rr);
      acc = frame_valid && frame_ready;
      @(negedge clk);
      if (acc) frame_valid = 1'b0;
    end
  endtask

  task automatic scan(input logic [41:0] segs, input logic [5:0] dps, input logic [5:0] r0v,
                      input logic [5:0] rrv, input int nb0,
                      input int oa, input logic [23:0] fda, input logic [5:0] fdpa,
                      input int ob, input logic [23:0] fdb, input logic [5:0] fdpb);
    for (int k = 0; k < 6; k++) begin
      if (k == oa) begin
        frame_valid = 1'b1; frame_data = fda; frame_dp = fdpa;
      end
      if (k == ob) begin
        frame_valid = 1'b1; frame_data = fdb; frame_dp = fdpb;
      end
      hold(k[3:0], 6'h20 >> k, segs[41-7*k -: 7], dps[5-k], (k == 0) ? nb0 : 4,
           r0v[5-k], rrv[5-k], 6);
    end
  endtask

  logic [41:0] seg_d;

  initial begin
    reset = 1'b1; frame_data = '0; frame_dp = '0; frame_valid = 1'b0;
    blank_lz = 1'b0; d = 4'd0; seg_sel = 6'h20;
    #2 reset = 1'b0;
    #1;
    cmp("reset_seg", seg, 7'h00);
    cmp("reset_dp", dp, 1'b0);
    cmp("reset_an", an, 6'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle frame of zeros; 123456 accepted at digit 2, ABCDEF offered while pending.
    scan({6{7'h3F}}, 6'h00, 6'b110000, 6'b110000, 3,
         2, 24'h123456, 6'h21, 4, 24'hABCDEF, 6'h00);
    // Wrap swaps in 123456; the held ABCDEF is taken one cycle after ready rises.
    scan({7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'h21, 6'b100000, 6'b000000, 4,
         -1, 24'h0, 6'h0, -1, 24'h0, 6'h0);
    scan({7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}, 6'h00, 6'b110000, 6'b110000, 4,
         2, 24'h000705, 6'h3F, -1, 24'h0, 6'h0);
    // Leading-zero suppression on 000705.
    blank_lz = 1'b1;
    seg_d = {7'h00, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h6D};
    scan(seg_d, 6'h3F, 6'h3F, 6'h3F, 4, -1, 24'h0, 6'h0, -1, 24'h0, 6'h0);

    // Digit changes faster than blanking: an never lights, wrap with nothing pending.
    for (int k = 0; k < 8; k++) begin
      hold(4'(k % 6), 6'h20 >> (k % 6), seg_d[41-7*(k%6) -: 7], 1'b1, 4, 1'b1, 1'b1, 1);
    end

    // d = 7 blanks everything; a frame taken there must not swap on 7 -> 0.
    blank_lz = 1'b0;
    frame_valid = 1'b1; frame_data = 24'h111111; frame_dp = 6'h00;
    hold(4'd7, 6'h20, 7'h00, 1'b0, 4, 1'b0, 1'b0, 6);
    hold(4'd0, 6'h20, 7'h3F, 1'b1, 4, 1'b0, 1'b0, 6);
    hold(4'd1, 6'h10, 7'h3F, 1'b1, 4, 1'b0, 1'b0, 1);

    // Reset mid-blank with a frame pending.
    #2 reset = 1'b0;
    d = 4'd0; seg_sel = 6'h20;
    #1;
    cmp("midreset_seg", seg, 7'h00);
    cmp("midreset_dp", dp, 1'b0);
    cmp("midreset_an", an, 6'h00);
    cmp("midreset_ready", frame_ready, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hold(4'd0, 6'h20, 7'h3F, 1'b0, 3, 1'b1, 1'b1, 6);
    hold(4'd1, 6'h10, 7'h3F, 1'b0, 4, 1'b1, 1'b1, 6);

    repeat (2) @(negedge clk);
    cmp("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d expectations queued", q.size());
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_frame_driver.md
Name: seg_frame_driver

Overview:
- Downstream of the 6-digit scan FSM: consumes its digit index (d) and one-hot digit select (seg_sel) and drives the physical 7-segment cathodes/anodes.
- Holds a 6-digit BCD/hex frame in a double buffer (load handshake plus tear-free swap at scan wrap), decodes the selected digit and inserts anti-ghosting blanking on every digit change.
- Optional leading-zero suppression.

Parameters:
- BLANK_CYCLES, 4, anode-off cycles inserted after each digit change (1..15; 0 disables blanking)
- SEG_ACTIVE_LOW, 0, 1 = seg/dp outputs inverted (common-anode parts)
- AN_ACTIVE_LOW, 0, 1 = an outputs inverted

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_data  in  24  six 4-bit digits; [23:20] = digit 0 (leftmost, seg_sel 6'h20), [3:0] = digit 5
- frame_dp  in  6  decimal points; bit 5 = digit 0
- frame_valid  in  1  frame offer
- frame_ready  out  1  driver can accept a frame
- blank_lz  in  1  leading-zero suppression enable (sampled live)
- d  in  4  digit index from scan FSM (0..5 valid)
- seg_sel  in  6  one-hot digit select from scan FSM
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point of current digit
- an  out  6  anode enables

Behaviour:
- Reset (reset=0, async): active buffer = 0, dp buffer = 0, pending empty, d_q = 0, blank_cnt = BLANK_CYCLES. seg, dp and an are at inactive level (logic 0 before polarity inversion). frame_ready = 1 after release.
- Handshake: transfer on frame_valid && frame_ready, which captures frame_data/frame_dp into the pending buffer and sets pending.
  - frame_ready = !pending (registered flag, no combinational path from frame_valid).
  - Data offered while frame_ready = 0 is ignored. The source must hold it.
- Swap: wrap is the cycle where d_q == 5 and d == 0.
  - On wrap with pending set: active <= pending buffer, pending <= 0, so frame_ready rises the next cycle.
  - On wrap with pending clear: active is unchanged. A frame accepted in that same cycle waits for the next wrap.
  - Active never changes mid-scan. A displayed frame is always complete.
- Blanking: digit change is the cycle where d != d_q. On that edge, d_q <= d and blank_cnt <= BLANK_CYCLES.
  - While blank_cnt != 0: an is inactive and blank_cnt decrements.
  - If d changes at cycle N, an is inactive from N+1 through N+BLANK_CYCLES and shows the new seg_sel at N+BLANK_CYCLES+1.
  - A further change during blanking restarts the count.
- Decode: all outputs are registered, with 1-cycle latency from d.
  - seg = hex pattern of active digit d_q (0-9, A-F).
  - dp = active dp bit for d_q.
  - an = seg_sel registered, gated by blanking.
- Leading-zero suppression: with blank_lz = 1, digit k (0..4) has seg forced to 0 if digits 0..k are all 0. Digit 5 always displays. dp is unaffected.
- d > 5: seg = 0, dp = 0, an = 0. This does not count as a wrap.
- seg_sel is not checked against d. an follows seg_sel as given.
- Polarity parameters invert only the final output stage. Reset levels are inactive after inversion.

Decomposition:
- Shared package:
  - 7-bit segment pattern constants for 0-F
  - NUM_DIGITS = 6
  - DIGIT_W = 4
  - digit-index constants matching the scan FSM (digit 0 ... digit 5)
- Sub-module seg7_hex_decode: combinational 4-bit to 7-bit lookup, instantiated once on the muxed digit.
- Handshake, swap, blanking and LZ logic stay in the top module.

Test Plan:
1. Reset then idle scan d = 0..5 with seg_sel 20,10,08,04,02,01 -> seg = 7'h3F (digit 0) on all digits; an shows each select after 4 blank cycles; frame_ready = 1.
2. Load frame_data = 24'h123456 mid-scan at d = 2 -> display stays 0 until the 5->0 wrap; from wrap+5 cycles, digit 0 shows 7'h06; frame_ready low until the cycle after wrap.
3. Second frame_valid while pending (frame_ready = 0) with 24'hABCDEF -> ignored; after wrap the first frame displays; the frame accepted after ready rises appears on the following wrap.
4. blank_lz = 1, frame 24'h000705 -> digits 0-2 have seg = 0; digit 3 = 7'h07, digit 4 = 7'h3F, digit 5 = 7'h6D; frame_dp = 6'h3F still lights dp on blanked digits.
5. d steps every cycle (faster than BLANK_CYCLES) -> an stays 0 continuously; d = 7 -> seg = 0, an = 0, no swap.
6. Assert reset mid-blank with pending set -> outputs inactive immediately (async); after release, pending cleared and frame_ready = 1.
